// File: rtl/controle_multiciclo.sv
// Multicycle control unit for the Redux-V datapath: sequences fetch, decode,
// execute, memory and writeback, handshaking with a variable-latency memory.
module controle_multiciclo #(
  parameter int OPW      = 4,
  parameter int ULAW     = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            ir_we,
  output logic            pc_we,
  output logic [ULAW-1:0] ula,
  output logic            b_mx,
  output logic            j_mx,
  output logic            r_mx,
  output logic            se_mx,
  output logic            d_mx,
  output logic            we,
  output logic            re,
  output logic            illegal,
  output logic            timeout,
  output logic [2:0]      state
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CL_BRANCH,
    CL_JUMP,
    CL_LOAD,
    CL_STORE,
    CL_ALUI,
    CL_ALUR
  } class_t;

  typedef struct packed {
    logic            mem_req;
    logic [ULAW-1:0] ula;
    logic            b_mx;
    logic            j_mx;
    logic            r_mx;
    logic            se_mx;
    logic            d_mx;
    logic            we;
    logic            re;
  } ctrl_t;

  state_t          cur;
  class_t          cls;
  class_t          dec_cls;
  ctrl_t           ctrl;
  logic [CW-1:0]   wait_cnt;
  logic [31:0]     op_wide;
  logic [3:0]      op_lo;
  logic            illegal_op;
  logic [ULAW-1:0] alu_code;

  assign op_wide    = 32'(opcode);
  assign op_lo      = op_wide[3:0];
  assign illegal_op = (op_wide >= 32'd16);

  always_comb begin
    dec_cls  = CL_ALUR;
    alu_code = '0;
    case (op_lo)
      4'd0:    dec_cls = CL_BRANCH;
      4'd1:    dec_cls = CL_JUMP;
      4'd2:    dec_cls = CL_LOAD;
      4'd3:    dec_cls = CL_STORE;
      4'd4: begin dec_cls = CL_ALUI; alu_code = ULAW'(4); end
      4'd5: begin dec_cls = CL_ALUI; alu_code = ULAW'(5); end
      4'd6:    alu_code = ULAW'(8);
      4'd7:    alu_code = ULAW'(9);
      default: alu_code = ULAW'(op_lo[2:0]);
    endcase
  end

  // The fetch and branch PC/IR strobes qualify on the same-cycle memory
  // completion and ALU zero flag, so they are gated from registered state.
  assign ir_we = (cur == FETCH) && ctrl.mem_req && mem_ready;
  assign pc_we = ir_we ||
                 ((cur == EXEC) && ((cls == CL_JUMP) || ((cls == CL_BRANCH) && zero)));

  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= FETCH;
      cls      <= CL_BRANCH;
      ctrl     <= '0;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      case (cur)
        FETCH: begin
          if (!ctrl.mem_req) begin
            ctrl.mem_req <= 1'b1;
            wait_cnt     <= '0;
          end else if (mem_ready) begin
            cur          <= DECODE;
            ctrl.mem_req <= 1'b0;
          end else if (wait_cnt == CW'(WAIT_MAX - 1)) begin
            cur      <= TRAP;
            ctrl     <= '0;
            timeout  <= 1'b1;
            wait_cnt <= wait_cnt + 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DECODE: begin
          ctrl <= '0;
          if (illegal_op) begin
            cur     <= TRAP;
            illegal <= 1'b1;
          end else begin
            cls <= dec_cls;
            case (dec_cls)
              CL_LOAD, CL_STORE: begin
                cur          <= MEM;
                wait_cnt     <= '0;
                ctrl.mem_req <= 1'b1;
                ctrl.we      <= (dec_cls == CL_STORE);
              end
              CL_BRANCH: begin
                cur       <= EXEC;
                ctrl.b_mx <= 1'b1;
              end
              CL_JUMP: begin
                cur       <= EXEC;
                ctrl.j_mx <= 1'b1;
              end
              CL_ALUI: begin
                cur        <= EXEC;
                ctrl.r_mx  <= 1'b1;
                ctrl.se_mx <= 1'b1;
                ctrl.d_mx  <= 1'b1;
                ctrl.ula   <= alu_code;
              end
              default: begin
                cur       <= EXEC;
                ctrl.d_mx <= 1'b1;
                ctrl.ula  <= alu_code;
              end
            endcase
          end
        end
        EXEC: begin
          if ((cls == CL_BRANCH) || (cls == CL_JUMP)) begin
            cur          <= FETCH;
            ctrl         <= '0;
            ctrl.mem_req <= 1'b1;
            wait_cnt     <= '0;
          end else begin
            // ALU ops keep their mux and ula selects through writeback
            cur     <= WB;
            ctrl.re <= 1'b1;
          end
        end
        MEM: begin
          if (mem_ready) begin
            ctrl <= '0;
            if (cls == CL_LOAD) begin
              cur     <= WB;
              ctrl.re <= 1'b1;
            end else begin
              cur          <= FETCH;
              ctrl.mem_req <= 1'b1;
              wait_cnt     <= '0;
            end
          end else if (wait_cnt == CW'(WAIT_MAX - 1)) begin
            cur      <= TRAP;
            ctrl     <= '0;
            timeout  <= 1'b1;
            wait_cnt <= wait_cnt + 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        WB: begin
          cur          <= FETCH;
          ctrl         <= '0;
          ctrl.mem_req <= 1'b1;
          wait_cnt     <= '0;
        end
        default: begin
          cur  <= TRAP;
          ctrl <= '0;
        end
      endcase
    end
  end

  assign mem_req = ctrl.mem_req;
  assign ula     = ctrl.ula;
  assign b_mx    = ctrl.b_mx;
  assign j_mx    = ctrl.j_mx;
  assign r_mx    = ctrl.r_mx;
  assign se_mx   = ctrl.se_mx;
  assign d_mx    = ctrl.d_mx;
  assign we      = ctrl.we;
  assign re      = ctrl.re;
  assign state   = cur;

endmodule
